// File: rtl/demux1to2_10_pkg.sv
// demux1to2_10_pkg: shared selector codes and default widths for the 10-bit datapath
package demux1to2_10_pkg;
    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;
    localparam int DFLT_WIDTH = 10;
    localparam int DFLT_CNT_W = 8;
    localparam int DFLT_DEPTH = 2;
endpackage

// File: rtl/demux1to2_10_fifo.sv
// fifo_sync_10: synchronous circular-buffer FIFO, head word reads as 0 while empty
module fifo_sync_10
    import demux1to2_10_pkg::*;
#(
    parameter int WIDTH = DFLT_WIDTH,
    parameter int DEPTH = DFLT_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0] cnt;
    logic do_push, do_pop;
    assign full = cnt == (AW+1)'(DEPTH);
    assign empty = cnt == '0;
    assign do_push = push && !full;
    assign do_pop = pop && !empty;
    // storage is not reset; the empty mask keeps stale entries off dout
    assign dout = empty ? '0 : mem[rptr];
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            cnt <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop) rptr <= rptr + 1'b1;
            cnt <= cnt + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end
endmodule

// File: rtl/demux1to2_10.sv
// demux1to2_10: routes each input word to FIFO A or B and counts words delivered per port
module demux1to2_10
    import demux1to2_10_pkg::*;
#(
    parameter int WIDTH = DFLT_WIDTH,
    parameter int DEPTH = DFLT_DEPTH,
    parameter int CNT_W = DFLT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] a_data,
    output logic [CNT_W-1:0] a_count,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [WIDTH-1:0] b_data,
    output logic [CNT_W-1:0] b_count
);
    logic rdy_en, a_full, b_full, a_empty, b_empty, accept;
    // holds in_ready low until the first edge after reset release
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rdy_en <= 1'b0;
        else rdy_en <= 1'b1;
    end
    assign in_ready = rdy_en && !rst && (in_sel == SEL_B ? !b_full : !a_full);
    assign accept = in_valid && in_ready;
    assign a_valid = !a_empty;
    assign b_valid = !b_empty;
    fifo_sync_10 #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_a (
        .clk(clk), .rst(rst), .push(accept && in_sel == SEL_A), .pop(a_ready),
        .din(in_data), .dout(a_data), .full(a_full), .empty(a_empty)
    );
    fifo_sync_10 #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_b (
        .clk(clk), .rst(rst), .push(accept && in_sel == SEL_B), .pop(b_ready),
        .din(in_data), .dout(b_data), .full(b_full), .empty(b_empty)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_count <= '0;
            b_count <= '0;
        end else begin
            if (a_valid && a_ready) a_count <= a_count + 1'b1;
            if (b_valid && b_ready) b_count <= b_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_demux1to2_10.sv
// tb_demux1to2_10: directed vector table plus scoreboarded sequences for demux1to2_10
module tb_demux1to2_10;
    logic clk = 1'b0, rst = 1'b1;
    logic in_valid = 1'b0, in_sel = 1'b0, a_ready = 1'b0, b_ready = 1'b0;
    logic [9:0] in_data = '0;
    logic in_ready, a_valid, b_valid;
    logic [9:0] a_data, b_data;
    logic [7:0] a_count, b_count;
    int n_vec = 0, n_bad = 0;
    logic [9:0] qa[$], qb[$];
    logic [7:0] ma, mb;

    typedef struct {
        logic v, s; logic [9:0] d; logic ar, br;
        logic rdy, av; logic [9:0] ad; logic bv; logic [9:0] bd; logic [7:0] ac, bc;
    } vec_t;
    vec_t tbl[11];

    demux1to2_10 dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_sel(in_sel), .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data), .a_count(a_count),
        .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data), .b_count(b_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic s, input logic [9:0] d, input logic ar, input logic br);
        @(negedge clk);
        in_valid = v; in_sel = s; in_data = d; a_ready = ar; b_ready = br;
        #1;
    endtask

    // one scoreboarded cycle: compare against the queue model, then update it as the edge will
    task automatic cyc(input logic v, input logic s, input logic [9:0] d, input logic ar, input logic br);
        logic er, pa, pb;
        drive(v, s, d, ar, br);
        er = s ? (qb.size() < 2) : (qa.size() < 2);
        chk("in_ready", int'(in_ready), int'(er));
        chk("a_valid", int'(a_valid), int'(qa.size() != 0));
        chk("b_valid", int'(b_valid), int'(qb.size() != 0));
        if (qa.size() != 0) chk("a_data", int'(a_data), int'(qa[0]));
        if (qb.size() != 0) chk("b_data", int'(b_data), int'(qb[0]));
        chk("a_count", int'(a_count), int'(ma));
        chk("b_count", int'(b_count), int'(mb));
        pa = ar && qa.size() != 0;
        pb = br && qb.size() != 0;
        if (pa) begin void'(qa.pop_front()); ma++; end
        if (pb) begin void'(qb.pop_front()); mb++; end
        if (v && er) begin
            if (s) qb.push_back(d);
            else qa.push_back(d);
        end
    endtask

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 10'h155, 1'b1, 1'b1, 1'b1, 1'b0, 10'h000, 1'b0, 10'h000, 8'd0, 8'd0};
        tbl[1]  = '{1'b1, 1'b1, 10'h2AA, 1'b1, 1'b1, 1'b1, 1'b1, 10'h155, 1'b0, 10'h000, 8'd0, 8'd0};
        tbl[2]  = '{1'b0, 1'b0, 10'h000, 1'b1, 1'b1, 1'b1, 1'b0, 10'h000, 1'b1, 10'h2AA, 8'd1, 8'd0};
        tbl[3]  = '{1'b1, 1'b1, 10'h001, 1'b1, 1'b0, 1'b1, 1'b0, 10'h000, 1'b0, 10'h000, 8'd1, 8'd1};
        tbl[4]  = '{1'b1, 1'b1, 10'h002, 1'b1, 1'b0, 1'b1, 1'b0, 10'h000, 1'b1, 10'h001, 8'd1, 8'd1};
        tbl[5]  = '{1'b1, 1'b1, 10'h003, 1'b1, 1'b0, 1'b0, 1'b0, 10'h000, 1'b1, 10'h001, 8'd1, 8'd1};
        tbl[6]  = '{1'b1, 1'b0, 10'h3FF, 1'b1, 1'b0, 1'b1, 1'b0, 10'h000, 1'b1, 10'h001, 8'd1, 8'd1};
        tbl[7]  = '{1'b0, 1'b0, 10'h000, 1'b1, 1'b0, 1'b1, 1'b1, 10'h3FF, 1'b1, 10'h001, 8'd1, 8'd1};
        tbl[8]  = '{1'b0, 1'b0, 10'h000, 1'b0, 1'b1, 1'b1, 1'b0, 10'h000, 1'b1, 10'h001, 8'd2, 8'd1};
        tbl[9]  = '{1'b0, 1'b0, 10'h000, 1'b0, 1'b1, 1'b1, 1'b0, 10'h000, 1'b1, 10'h002, 8'd2, 8'd2};
        tbl[10] = '{1'b0, 1'b0, 10'h000, 1'b1, 1'b1, 1'b1, 1'b0, 10'h000, 1'b0, 10'h000, 8'd2, 8'd3};

        #1;
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_a_valid", int'(a_valid), 0);
        chk("rst_b_valid", int'(b_valid), 0);
        chk("rst_counts", int'({a_count, b_count}), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);

        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].v, tbl[i].s, tbl[i].d, tbl[i].ar, tbl[i].br);
            chk($sformatf("v%0d_in_ready", i), int'(in_ready), int'(tbl[i].rdy));
            chk($sformatf("v%0d_a_valid", i), int'(a_valid), int'(tbl[i].av));
            chk($sformatf("v%0d_a_data", i), int'(a_data), int'(tbl[i].ad));
            chk($sformatf("v%0d_b_valid", i), int'(b_valid), int'(tbl[i].bv));
            chk($sformatf("v%0d_b_data", i), int'(b_data), int'(tbl[i].bd));
            chk($sformatf("v%0d_a_count", i), int'(a_count), int'(tbl[i].ac));
            chk($sformatf("v%0d_b_count", i), int'(b_count), int'(tbl[i].bc));
        end

        // full A with a simultaneous pop still refuses the push that cycle
        ma = 8'd2; mb = 8'd3;
        cyc(1'b1, 1'b0, 10'h00A, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 10'h00B, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 10'h010, 1'b1, 1'b0);
        chk("full_in_ready_low", int'(in_ready), 0);
        cyc(1'b1, 1'b0, 10'h010, 1'b1, 1'b0);
        chk("full_in_ready_next", int'(in_ready), 1);
        chk("full_head_order", int'(a_data), 10'h00B);
        repeat (3) cyc(1'b0, 1'b0, 10'h000, 1'b1, 1'b1);
        chk("full_drained", qa.size(), 0);

        // asynchronous reset mid-stream with A holding two words
        cyc(1'b1, 1'b0, 10'h111, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 10'h222, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 10'h000, 1'b0, 1'b0);
        chk("pre_rst_a_valid", int'(a_valid), 1);
        #1 rst = 1'b1;
        #1;
        chk("arst_a_valid", int'(a_valid), 0);
        chk("arst_a_data", int'(a_data), 0);
        chk("arst_b_valid", int'(b_valid), 0);
        chk("arst_a_count", int'(a_count), 0);
        chk("arst_b_count", int'(b_count), 0);
        chk("arst_in_ready", int'(in_ready), 0);
        qa.delete(); qb.delete(); ma = '0; mb = '0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rel_in_ready_before_edge", int'(in_ready), 0);
        @(posedge clk);
        #1;
        chk("rel_in_ready", int'(in_ready), 1);
        chk("rel_a_valid", int'(a_valid), 0);
        chk("rel_a_count", int'(a_count), 0);

        for (int i = 0; i < 300; i++) cyc(1'b1, i[0], i[9:0], 1'b1, 1'b1);
        repeat (2) cyc(1'b0, 1'b0, 10'h000, 1'b1, 1'b1);
        chk("stream_a_count", int'(a_count), 150);
        chk("stream_b_count", int'(b_count), 150);
        for (int i = 0; i < 512; i++) cyc(1'b1, 1'b0, i[9:0], 1'b1, 1'b1);
        repeat (2) cyc(1'b0, 1'b0, 10'h000, 1'b1, 1'b1);
        chk("wrap_a_count", int'(a_count), 150);

        for (int i = 0; i < 10000; i++)
            cyc(1'($urandom_range(1)), 1'($urandom_range(1)), 10'($urandom), 1'($urandom_range(1)), 1'($urandom_range(1)));
        repeat (4) cyc(1'b0, 1'b0, 10'h000, 1'b1, 1'b1);
        chk("rand_a_empty", int'(a_valid), 0);
        chk("rand_b_empty", int'(b_valid), 0);
        chk("rand_model_a_empty", qa.size(), 0);
        chk("rand_model_b_empty", qb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/demux1to2_10.md
# demux1to2_10

Routes a stream of 10-bit words from one producer to one of two consumers, selected per word by `in_sel`. It is the distributing counterpart of the 2:1 selection path in the datapath. Each destination has its own small FIFO, so a stalled consumer blocks only words addressed to it. Per-destination 8-bit word counters support debug and performance readout.

## Interface
- `WIDTH`, 10, data word width.
- `DEPTH`, 2, entries per destination FIFO; must be a power of two, 2 or larger.
- `CNT_W`, 8, width of each delivered-word counter.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  producer offers a word.
- `in_ready`  out  1  block accepts the word this cycle.
- `in_data`  in  WIDTH  word.
- `in_sel`  in  1  destination: 0 = A, 1 = B. Qualified by `in_valid`.
- `a_valid` / `b_valid`  out  1  destination FIFO non-empty.
- `a_ready` / `b_ready`  in  1  consumer takes the head word.
- `a_data` / `b_data`  out  WIDTH  head word of each FIFO.
- `a_count` / `b_count`  out  CNT_W  words delivered to A / B; wraps modulo 2^CNT_W.

## Operation
- Accept: a transfer happens when `in_valid && in_ready`. The word is pushed into FIFO A if `in_sel=0`, or FIFO B if `in_sel=1`.
- `in_ready` is combinational: `!rst && (in_sel ? !b_full : !a_full)`.
  - It depends only on the selected FIFO. A full B never stalls a word bound for A.
- Output: a pop happens when `x_valid && x_ready`. `x_data` shows the FIFO head and holds stable while `x_valid && !x_ready`.
- FIFO: circular buffer with read/write pointers and an occupancy count from 0 to DEPTH.
  - `x_full` = (count == DEPTH).
  - `x_valid` = (count != 0).
- Counters: `x_count` increments on each pop from FIFO x, not on push. It wraps from 2^CNT_W−1 to 0.
- Words within one destination stay in order. There is no ordering guarantee between A and B.

## Timing
- Reset (asynchronous, takes effect immediately):
  - pointers, occupancy and counters are set to 0.
  - `a_valid`, `b_valid`, `a_data`, `b_data`, `a_count` and `b_count` are 0.
  - `in_ready` is 0 while `rst` is high. It becomes 1 after the first edge following deassertion.
  - If reset is asserted mid-stream, every buffered word is discarded and the counters clear.
- Latency: a word pushed at edge N appears on `x_valid`/`x_data` right after edge N, so the consumer can pop it at edge N+1. There is no combinational path from `in_data` to `x_data`.
- Push and pop on the same FIFO in the same cycle:
  - When the FIFO is not full, both take effect and the occupancy count is unchanged.
  - When the FIFO is full, the push is refused (`in_ready=0`) even if a pop happens that cycle. No pass-through on full.
- Push and pop on an empty FIFO in the same cycle cannot happen, because `x_valid=0`. The pushed word appears next cycle.
- Pointers wrap modulo DEPTH. The occupancy count disambiguates full from empty.
- `x_ready` asserted while `x_valid=0` has no effect. `in_sel` is ignored when `in_valid=0`.
- Throughput: one accept per cycle when the selected FIFO is not full; one pop per destination per cycle.

## Structure
- Shared header/package holds:
  - `SEL_A` = 1'b0 and `SEL_B` = 1'b1.
  - default `WIDTH` = 10 and `CNT_W` = 8, shared with the 10-bit mux datapath.
- Sub-module `fifo_sync_10`, instantiated twice: a parameterised synchronous FIFO with ports push, pop, din, dout, full, empty, and reset on `clk`/`rst`.
- The top level contains the push steering, the `in_ready` logic and the two pop counters.

## Test plan
- Reset: assert `rst` mid-stream with A holding 2 words → all outputs 0 immediately and `in_ready=0`. After release, `a_valid=0` and `a_count=0`.
- Single route: push 0x155 with `in_sel=0`, then 0x2AA with `in_sel=1`, both consumers ready → A delivers 0x155, B delivers 0x2AA, each one cycle after its push. Both counts become 1.
- Blocking isolation: `b_ready=0`; push 0x001, 0x002 to B, then 0x003 to B → `in_ready=0` on the third word. Switch `in_sel=0` with 0x3FF → `in_ready=1` and A delivers 0x3FF.
- Full boundary: with A full, hold `a_ready=1` and offer 0x010 to A in the same cycle → `in_ready=0` that cycle and 1 the next. Order out of A is preserved.
- Streaming and wrap: push 300 words (`in_data` = index mod 1024) alternating A/B, consumers always ready → in-order delivery per port, one word per cycle, and `a_count = b_count = 150 mod 256 = 150`. Then 512 more to A → `a_count` wraps to 150.
- Random backpressure: random `in_valid`, `in_sel`, `a_ready`, `b_ready` over 10k cycles against a scoreboard → no loss, duplication or reordering per port.
